// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 4-to-16 decoder: visits eligible channels in ascending order,
// holds each for dwell+1 cycles and inserts a one-cycle sel_en=0 gap between channels.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [3:0]         last_ch,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        skip_mask,
  output logic [3:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  state_e             state_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               cfg_mode_q;
  logic [3:0]         cfg_last_q;
  logic [DWELL_W-1:0] cfg_dwell_q;
  logic [15:0]        cfg_mask_q;

  // Returns {found, index} of the lowest eligible channel at or above lo.
  function automatic logic [4:0] find_from(input logic [15:0] mask, input logic [3:0] last,
                                           input logic [4:0] lo);
    logic [4:0] res;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i >= int'(lo) && i <= int'(last) && !mask[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  logic [4:0] first_in;
  logic [4:0] first_cfg;
  logic [4:0] next_cfg;

  assign first_in  = find_from(skip_mask, last_ch, 5'd0);
  assign first_cfg = find_from(cfg_mask_q, cfg_last_q, 5'd0);
  assign next_cfg  = find_from(cfg_mask_q, cfg_last_q, {1'b0, sel} + 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cfg_mode_q  <= 1'b0;
      cfg_last_q  <= '0;
      cfg_dwell_q <= '0;
      cfg_mask_q  <= '0;
      sel         <= '0;
      sel_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sel    <= '0;
          sel_en <= 1'b0;
          busy   <= 1'b0;
          if (start && !stop) begin
            cfg_mode_q  <= mode;
            cfg_last_q  <= last_ch;
            cfg_dwell_q <= dwell;
            cfg_mask_q  <= skip_mask;
            if (first_in[4]) begin
              state_q <= StActive;
              sel     <= first_in[3:0];
              sel_en  <= 1'b1;
              busy    <= 1'b1;
              cnt_q   <= dwell;
            end else begin
              done <= 1'b1;
            end
          end
        end
        StActive: begin
          if (stop) begin
            state_q <= StIdle;
            sel     <= '0;
            sel_en  <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt_q == '0) begin
            sel_en <= 1'b0;
            if (next_cfg[4]) begin
              state_q <= StGap;
            end else if (!cfg_mode_q) begin
              state_q <= StIdle;
              sel     <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StGap;
              wrap    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        StGap: begin
          if (stop) begin
            state_q <= StIdle;
            sel     <= '0;
            sel_en  <= 1'b0;
            busy    <= 1'b0;
          end else begin
            // No higher eligible channel means this gap precedes a wrap.
            state_q <= StActive;
            sel     <= next_cfg[4] ? next_cfg[3:0] : first_cfg[3:0];
            sel_en  <= 1'b1;
            cnt_q   <= cfg_dwell_q;
          end
        end
        default: begin
          state_q <= StIdle;
          sel     <= '0;
          sel_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 4-to-16 decoder. It drives the decoder's 4-bit select and enable so that the decoder's outputs are activated one at a time.
- Channels are visited in ascending order, each for a programmable dwell time.
- Masked channels are skipped.
- Every channel change has a one-cycle break-before-make gap.
- Runs as a single sweep or continuously, with start/stop control and busy/done status.

Parameters:
DWELL_W, 8, width of the dwell count; each channel is held for dwell+1 cycles.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a scan; sampled only in IDLE
stop  input  1  abort the current scan; takes effect on the next edge
mode  input  1  0 = single sweep, 1 = continuous (wrap)
last_ch  input  4  highest channel index in the scan range (0..last_ch)
dwell  input  DWELL_W  hold cycles minus one per channel
skip_mask  input  16  bit i = 1 means channel i is skipped
sel  output  4  channel index, drives the decoder's in[3:0]
sel_en  output  1  drives the decoder's en
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a single sweep completes
wrap  output  1  one-cycle pulse on the gap cycle preceding a wrap to the first channel

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE.
  - sel=0, sel_en=0, busy=0, done=0, wrap=0.
  - Dwell counter and configuration registers cleared.
  - Reset mid-scan aborts immediately; no done pulse.
- All outputs are registered. "Cycle n" means the cycle after edge n; start is sampled at edge 0.
- States: IDLE, ACTIVE, GAP.
- Eligible channel: index i <= last_ch with skip_mask[i]=0.
  - first = lowest eligible index.
  - next(c) = lowest eligible index greater than c.
- IDLE:
  - sel=0, sel_en=0, busy=0.
  - If start=1 and stop=0: capture mode, last_ch, dwell and skip_mask. These are held for the whole scan; later input changes are ignored.
  - If an eligible channel exists: go to ACTIVE with sel=first, sel_en=1, busy=1, counter=dwell.
  - If no eligible channel exists: stay IDLE, done=1 for one cycle, busy stays 0.
  - stop=1 overrides start.
- ACTIVE:
  - sel_en=1.
  - The counter decrements each cycle; the channel is held for exactly dwell+1 cycles (dwell=0 gives 1 cycle).
  - When the counter reaches 0:
    - If next(sel) exists: go to GAP.
    - Else if mode=0: go to IDLE with done=1 for the first IDLE cycle, busy=0, sel=0.
    - Else (mode=1): go to GAP with wrap=1 during that GAP cycle.
- GAP:
  - Lasts exactly one cycle with sel_en=0 and sel holding the previous channel.
  - Then go to ACTIVE with sel = next(sel), or first on a wrap, and counter reloaded from the captured dwell.
- stop=1 in ACTIVE or GAP: at the next edge, enter IDLE with sel_en=0, busy=0, sel=0, no done and no wrap.
- start while busy=1 is ignored.
- done and wrap are never asserted in the same cycle.
- sel_en=1 only in ACTIVE, so the decoder never sees two channels without an intervening sel_en=0 cycle.
- last_ch=0 with channel 0 eligible, mode=1: the scan toggles ch0 (dwell+1 cycles), then GAP with wrap=1, repeating.

Test Plan:
- Single sweep (mode=0, last_ch=3, dwell=1, mask=0000, start at edge 0):
  - Channels: sel_en=1 on cycles 1-2 (sel=0), 4-5 (sel=1), 7-8 (sel=2), 10-11 (sel=3).
  - sel_en=0 on cycles 3, 6, 9.
  - Cycle 12: done=1, busy=0, sel=0. busy=1 on cycles 1-11.
- Masking (mode=0, last_ch=3, dwell=0, mask=0005):
  - Cycle 1 sel=1 with sel_en=1; cycle 2 gap; cycle 3 sel=3 with sel_en=1; cycle 4 done=1.
- All masked (mask=FFFF, last_ch=F, start):
  - Cycle 1 done=1, busy=0, sel_en=0.
  - No further activity.
- Continuous (mode=1, last_ch=1, dwell=0, mask=0):
  - sel sequence 0 (c1), gap (c2), 1 (c3), gap with wrap=1 (c4), 0 (c5), and so on.
  - done is never asserted.
  - Changing dwell to 5 mid-run has no effect.
- Stop and restart:
  - During the c4 dwell of the single sweep, assert stop for 1 cycle: next cycle shows sel_en=0, busy=0, done=0.
  - start together with stop in IDLE is ignored.
  - A subsequent start restarts from channel 0.
- Async reset:
  - Drop rst_n mid-cycle during ACTIVE: all outputs go to 0 immediately, without waiting for a clock edge.
  - After release, start behaves exactly as in the single-sweep scenario.
